// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve/play/score sequencing, ball stepping,
// wall and paddle bounces, and per-hit speed-up with a floor.
module pong_ball_engine #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int COORD_W       = 6,
    parameter int PADDLE_HEIGHT = 6,
    parameter int P1_COL        = 1,
    parameter int P2_COL        = GAME_WIDTH - 2,
    parameter int SPEED_INIT    = 1250000,
    parameter int SPEED_MIN     = 312500,
    parameter int SPEED_STEP    = 125000,
    parameter int SERVE_DELAY   = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               game_active,
    input  logic [COORD_W-1:0] paddle1_y,
    input  logic [COORD_W-1:0] paddle2_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               ball_visible,
    output logic               p1_score,
    output logic               p2_score
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY,
        SCORED
    } state_t;

    localparam int CW1 = COORD_W + 1;

    localparam logic [COORD_W-1:0] X_CTR   = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_CTR   = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_L_HIT = COORD_W'(P1_COL + 1);
    localparam logic [COORD_W-1:0] X_R_HIT = COORD_W'(P2_COL - 1);
    localparam logic [CW1-1:0]     PAD_H   = CW1'(PADDLE_HEIGHT);

    localparam logic [23:0] SPD_INIT = 24'(SPEED_INIT);
    localparam logic [23:0] SPD_MIN  = 24'(SPEED_MIN);
    localparam logic [23:0] SPD_STEP = 24'(SPEED_STEP);
    localparam logic [24:0] SPD_KNEE = 25'(SPEED_MIN) + 25'(SPEED_STEP);
    localparam logic [31:0] SRV_LAST = 32'(SERVE_DELAY - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic [23:0]        speed_q, speed_d;
    logic [23:0]        tick_q, tick_d;
    logic [31:0]        srv_q, srv_d;
    logic               p1_win_q, p1_win_d;

    // Window test is done one bit wider so paddles near the top code never wrap.
    function automatic logic in_win(
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] by
    );
        logic [CW1-1:0] lo;
        logic [CW1-1:0] b;
        lo = {1'b0, py};
        b  = {1'b0, by};
        return (b >= lo) && (b < lo + PAD_H);
    endfunction

    function automatic logic [23:0] faster(input logic [23:0] s);
        if ({1'b0, s} >= SPD_KNEE) begin
            return s - SPD_STEP;
        end
        return SPD_MIN;
    endfunction

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        speed_d  = speed_q;
        tick_d   = tick_q;
        srv_d    = srv_q;
        p1_win_d = p1_win_q;

        unique case (state_q)
            IDLE: begin
                x_d     = X_CTR;
                y_d     = Y_CTR;
                speed_d = SPD_INIT;
                tick_d  = '0;
                srv_d   = '0;
                if (game_active) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                x_d    = X_CTR;
                y_d    = Y_CTR;
                tick_d = '0;
                if (srv_q == SRV_LAST) begin
                    srv_d   = '0;
                    state_d = PLAY;
                end else begin
                    srv_d = srv_q + 32'd1;
                end
            end
            PLAY: begin
                if (tick_q == speed_q - 24'd1) begin
                    tick_d = '0;
                    // A miss freezes the ball so the scoring cycle sees where it left.
                    if (!dir_x_q && x_q == '0) begin
                        state_d  = SCORED;
                        p1_win_d = 1'b0;
                    end else if (dir_x_q && x_q == X_MAX) begin
                        state_d  = SCORED;
                        p1_win_d = 1'b1;
                    end else begin
                        if (dir_y_q && y_q == Y_MAX) begin
                            dir_y_d = 1'b0;
                            y_d     = y_q - 1'b1;
                        end else if (!dir_y_q && y_q == '0) begin
                            dir_y_d = 1'b1;
                            y_d     = y_q + 1'b1;
                        end else begin
                            y_d = dir_y_q ? y_q + 1'b1 : y_q - 1'b1;
                        end

                        if (!dir_x_q && x_q == X_L_HIT && in_win(paddle1_y, y_q)) begin
                            dir_x_d = 1'b1;
                            x_d     = x_q + 1'b1;
                            speed_d = faster(speed_q);
                        end else if (dir_x_q && x_q == X_R_HIT && in_win(paddle2_y, y_q)) begin
                            dir_x_d = 1'b0;
                            x_d     = x_q - 1'b1;
                            speed_d = faster(speed_q);
                        end else begin
                            x_d = dir_x_q ? x_q + 1'b1 : x_q - 1'b1;
                        end
                    end
                end else begin
                    tick_d = tick_q + 24'd1;
                end
            end
            SCORED: begin
                x_d     = X_CTR;
                y_d     = Y_CTR;
                speed_d = SPD_INIT;
                tick_d  = '0;
                srv_d   = '0;
                dir_x_d = p1_win_q;
                dir_y_d = ~dir_y_q;
                state_d = SERVE;
            end
        endcase

        if (!game_active) begin
            state_d = IDLE;
            x_d     = X_CTR;
            y_d     = Y_CTR;
            speed_d = SPD_INIT;
            tick_d  = '0;
            srv_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= X_CTR;
            y_q      <= Y_CTR;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            speed_q  <= SPD_INIT;
            tick_q   <= '0;
            srv_q    <= '0;
            p1_win_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            speed_q  <= speed_d;
            tick_q   <= tick_d;
            srv_q    <= srv_d;
            p1_win_q <= p1_win_d;
        end
    end

    assign ball_x       = x_q;
    assign ball_y       = y_q;
    assign ball_visible = (state_q == PLAY);
    assign p1_score     = (state_q == SCORED) && p1_win_q;
    assign p2_score     = (state_q == SCORED) && !p1_win_q;

endmodule
